// File: rtl/ram_dump_reader.sv
// ram_dump_reader: walks a RAM address range, showing each 4-bit word and the
// low nibble of its address on two display digits for HOLD_CYCLES clocks.
module ram_dump_reader #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk_100M,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    input  logic [3:0]        ram_q,
    output logic [3:0]        digit0,
    output logic [3:0]        digit1,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    // Hold counter only has to reach HOLD_CYCLES-1.
    localparam int unsigned     CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              start_q;
    logic              trigger;
    logic              hold_last;
    logic [ADDR_W-1:0] end_q;
    logic [CNT_W-1:0]  cnt;

    // The dump reader only ever reads.
    assign ram_wren  = 1'b0;
    assign trigger   = start & ~start_q;
    assign hold_last = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; stop always returns to IDLE and beats a same-cycle trigger.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger && !stop) next_state = READ;
            READ:    next_state = stop ? IDLE : CAPTURE;
            CAPTURE: next_state = stop ? IDLE : HOLD;
            HOLD: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (hold_last) begin
                    next_state = (ram_addr == end_q) ? FINISH : READ;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address, display, hold counter and status pulses.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            ram_addr <= '0;
            end_q    <= '0;
            digit0   <= '0;
            digit1   <= '0;
            cnt      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            start_q <= start;
            valid   <= (state == CAPTURE) && (next_state == HOLD);
            done    <= (next_state == FINISH);
            busy    <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (next_state == READ) begin
                        ram_addr <= start_addr;
                        end_q    <= end_addr;
                    end
                end
                CAPTURE: begin
                    if (next_state == HOLD) begin
                        digit0 <= ram_q;
                        digit1 <= ram_addr[3:0];
                        cnt    <= '0;
                    end
                end
                HOLD: begin
                    if (next_state == READ) begin
                        ram_addr <= ram_addr + ADDR_W'(1);
                    end else if (next_state == HOLD) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Bench for ram_dump_reader: timeline model of the dump plus literal word checks.
module tb_ram_dump_reader;

    localparam int unsigned H  = 4;
    localparam int unsigned AW = 10;
    localparam int          P  = H + 2;

    logic          clk_100M = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          stop     = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr   = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [3:0]    ram_q = 4'h0;
    logic [3:0]    digit0;
    logic [3:0]    digit1;
    logic          valid;
    logic          busy;
    logic          done;

    ram_dump_reader #(.HOLD_CYCLES(H), .ADDR_W(AW)) dut (
        .clk_100M  (clk_100M),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .start_addr(start_addr),
        .end_addr  (end_addr),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_q     (ram_q),
        .digit0    (digit0),
        .digit1    (digit1),
        .valid     (valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_100M = ~clk_100M;

    // RAM with one-cycle read latency, preloaded mem[a] = a[3:0] ^ 5.
    logic [3:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 4'(i) ^ 4'h5;
    always @(posedge clk_100M) ram_q <= mem[ram_addr];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a dump of n words started at edge t0 shows word k at
    // r = k*P+2, pulses done at r = n*P and goes idle at r = n*P+1.
    bit            m_active     = 1'b0;
    bit            m_prev_start = 1'b0;
    int            m_r = 0, m_n = 0, m_k = 0, m_ph = 0;
    logic [AW-1:0] m_s       = '0;
    logic [AW-1:0] exp_addr  = '0;
    logic [3:0]    exp_d0    = '0;
    logic [3:0]    exp_d1    = '0;
    logic          exp_valid = 1'b0;
    logic          exp_busy  = 1'b0;
    logic          exp_done  = 1'b0;

    always @(posedge clk_100M or negedge rst_n) begin
        cyc++;
        if (!rst_n) begin
            m_active = 1'b0; m_prev_start = 1'b0;
            exp_addr = '0; exp_d0 = '0; exp_d1 = '0;
            exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_done  = 1'b0;
            if (m_active) begin
                m_r++;
                if (stop || m_r > m_n * P) begin
                    m_active = 1'b0;
                    exp_busy = 1'b0;
                end else if (m_r == m_n * P) begin
                    exp_done = 1'b1;
                end else begin
                    m_k = m_r / P;
                    m_ph = m_r % P;
                    exp_addr = AW'(m_s + m_k);
                    if (m_ph == 2) begin
                        exp_valid = 1'b1;
                        exp_d1 = exp_addr[3:0];
                        exp_d0 = mem[exp_addr];
                    end
                end
            end else if (start && !m_prev_start && !stop) begin
                m_active = 1'b1;
                m_r = 0;
                m_s = start_addr;
                m_n = int'(AW'(end_addr - start_addr)) + 1;
                exp_addr = start_addr;
                exp_busy = 1'b1;
            end
            m_prev_start = start;
        end
    end

    // Observed pulses for the literal checks.
    logic [7:0] pulse_q[$];
    int         pulse_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;

    // Compare process: every output against the model, mid-cycle.
    always @(negedge clk_100M) begin
        if (rst_n && chk_en) begin
            check("ram_addr", 32'(ram_addr), 32'(exp_addr));
            check("digit0",   32'(digit0),   32'(exp_d0));
            check("digit1",   32'(digit1),   32'(exp_d1));
            check("valid",    32'(valid),    32'(exp_valid));
            check("busy",     32'(busy),     32'(exp_busy));
            check("done",     32'(done),     32'(exp_done));
            check("ram_wren", 32'(ram_wren), 32'd0);
            if (valid === 1'b1) begin
                pulse_q.push_back({digit1, digit0});
                pulse_cyc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    task automatic clear_log();
        pulse_q.delete();
        pulse_cyc.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    // One-cycle start pulse; returns 1 time unit after the trigger edge.
    task automatic trig(input logic [AW-1:0] s, input logic [AW-1:0] e, output int t0);
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        tick(1);
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic check_pulses(input string tag, input int n,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] ea [4];
        ea = '{e0, e1, e2, e3};
        check({tag, "_count"}, 32'(pulse_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < pulse_q.size()) check({tag, "_word"}, 32'(pulse_q[i]), 32'(ea[i]));
            if (i > 0 && i < pulse_q.size())
                check({tag, "_spacing"}, 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(P));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"},  32'(ram_addr), 32'd0);
        check({tag, "_d0"},    32'(digit0),   32'd0);
        check({tag, "_d1"},    32'(digit1),   32'd0);
        check({tag, "_valid"}, 32'(valid),    32'd0);
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_done"},  32'(done),     32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        // Reset state.
        tick(3);
        check_zero("reset");
        rst_n = 1'b1;
        tick(2);
        chk_en = 1'b1;

        // 3..5 dump.
        clear_log();
        trig(10'd3, 10'd5, t0);
        tick(3 * P + 3);
        check_pulses("dump3to5", 3, 8'h36, 8'h41, 8'h50, 8'h00);
        check("dump3to5_done_cnt", 32'(done_cnt), 32'd1);
        if (pulse_q.size() == 3) check("dump3to5_done_lag", 32'(done_cyc - pulse_cyc[2]), 32'(H));
        check("dump3to5_busy_after", 32'(busy), 32'd0);

        // Wrap-around dump 1022..1.
        clear_log();
        trig(10'd1022, 10'd1, t0);
        tick(4 * P + 3);
        check_pulses("wrap", 4, 8'hEB, 8'hFA, 8'h05, 8'h14);
        check("wrap_done_cnt", 32'(done_cnt), 32'd1);
        check("wrap_last_addr", 32'(ram_addr), 32'd1);

        // Single word.
        clear_log();
        trig(10'd7, 10'd7, t0);
        tick(P + 3);
        check_pulses("single", 1, 8'h72, 8'h00, 8'h00, 8'h00);
        check("single_done_cnt", 32'(done_cnt), 32'd1);
        check("single_done_time", 32'(done_cyc - t0), 32'd6);

        // Stop during second HOLD, with start held for 20+ cycles.
        clear_log();
        start_addr = 10'd3;
        end_addr   = 10'd5;
        start      = 1'b1;
        tick(1);
        tick(9);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(10);
        start = 1'b0;
        tick(4 * P);
        check_pulses("stop", 2, 8'h36, 8'h41, 8'h00, 8'h00);
        check("stop_d1", 32'(digit1), 32'h4);
        check("stop_d0", 32'(digit0), 32'h1);
        check("stop_addr", 32'(ram_addr), 32'd4);
        check("stop_done_cnt", 32'(done_cnt), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);

        // Stop beats a same-cycle trigger in IDLE.
        clear_log();
        start_addr = 10'd7;
        end_addr   = 10'd7;
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(3);
        start = 1'b0;
        tick(2 * P);
        check("stopwins_count", 32'(pulse_q.size()), 32'd0);
        check("stopwins_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-HOLD, then a fresh dump.
        clear_log();
        trig(10'd3, 10'd5, t0);
        tick(3);
        @(negedge clk_100M);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        #1;
        rst_n = 1'b1;
        tick(2);
        check("async_rst_done_cnt", 32'(done_cnt), 32'd0);
        clear_log();
        trig(10'd10, 10'd11, t0);
        tick(2 * P + 3);
        check_pulses("after_rst", 2, 8'hAF, 8'hBE, 8'h00, 8'h00);
        check("after_rst_done_cnt", 32'(done_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_dump_reader.md
RAM_DUMP_READER -- requirements
Module: ram_dump_reader

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000, number of clk_100M cycles each read word stays on display (≥1).
REQ-002 Parameter ADDR_W, default 10, RAM address width (1K words).
REQ-003 clk_100M  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level from synchronised button; rising edge starts a dump.
REQ-006 stop  input  1  synchronous abort, active-high, level.
REQ-007 start_addr  input  ADDR_W  first address to read, sampled on start edge.
REQ-008 end_addr  input  ADDR_W  last address to read, sampled on start edge.
REQ-009 ram_addr  output  ADDR_W  read address to ram_dp1_1Kx4 address port.
REQ-010 ram_wren  output  1  RAM write enable; constant 0.
REQ-011 ram_q  input  4  RAM read data; valid one clock after ram_addr is presented.
REQ-012 digit0  output  4  data nibble of current word, to adpt_out digit0.
REQ-013 digit1  output  4  ram_addr[3:0] of current word, to adpt_out digit1.
REQ-014 valid  output  1  one-cycle pulse when digit0/digit1 take a new word.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after the end_addr word finishes its hold.

Function
REQ-017 Start detect: register start_q; trigger = start & ~start_q; held level gives exactly one trigger.
REQ-018 States: IDLE, READ, CAPTURE, HOLD, FINISH; one-hot or binary, no other reachable states.
REQ-019 IDLE: on trigger and stop=0, latch start_addr into ram_addr and end_addr into end register, go to READ.
REQ-020 READ (1 cycle): ram_addr stable, go to CAPTURE.
REQ-021 CAPTURE (1 cycle): digit0 <= ram_q, digit1 <= ram_addr[3:0], valid <= 1 in the following cycle, hold counter <= 0, go to HOLD.
REQ-022 HOLD: counter increments each cycle; after exactly HOLD_CYCLES cycles in HOLD: if ram_addr == end register go to FINISH, else ram_addr <= ram_addr+1 and go to READ.
REQ-023 Per-word period = HOLD_CYCLES + 2 cycles; valid pulses spaced exactly that apart.
REQ-024 Address increment is modulo 2^ADDR_W: 1023+1 = 0; end_addr < start_addr dumps through wrap (e.g. 1022,1023,0,1).
REQ-025 start_addr == end_addr: exactly one word read, then FINISH.
REQ-026 FINISH (1 cycle): done=1, go to IDLE; digits keep last word.
REQ-027 stop=1 in READ/CAPTURE/HOLD/FINISH: next state IDLE, no valid/done pulse, digit0/digit1/ram_addr hold current values.
REQ-028 stop=1 and trigger in same IDLE cycle: stop wins, remain IDLE.
REQ-029 Trigger while busy ignored; start_addr/end_addr changes while busy ignored.
REQ-030 ram_wren tied 0; block never writes RAM.
REQ-031 busy is a registered output: high from the cycle after trigger until the cycle after FINISH.

Reset
REQ-032 rst_n=0 forces immediately, irrespective of clock: state IDLE, ram_addr=0, digit0=0, digit1=0, valid=0, busy=0, done=0, start_q=0, counter=0.
REQ-033 Reset mid-dump aborts without done pulse; first trigger after rst_n deasserts starts a fresh dump.

Verification (HOLD_CYCLES=4, RAM preloaded mem[a]=a[3:0]^4'h5)
REQ-034 start_addr=3, end_addr=5, start edge -> valid pulses 6 cycles apart with (digit1,digit0)=(3,6),(4,1),(5,0); done one cycle after third hold; busy then 0.
REQ-035 start_addr=1022, end_addr=1 -> ram_addr sequence 1022,1023,0,1; digit1=E,F,0,1; exactly 4 valid pulses, one done.
REQ-036 start_addr=end_addr=7 -> single valid with (7,2), done 6 cycles after READ entry.
REQ-037 stop asserted during second HOLD of a 3..5 dump -> IDLE next cycle, digits stay (4,1), no done; start held high for 20 cycles triggers only once.
REQ-038 rst_n pulsed low mid-HOLD (asynchronous to clk) -> all outputs 0 before next clock edge; start edge after release dumps normally.
